// File: rtl/muldiv_lock_client_pkg.sv
// Shared MDU op encoding, client FSM states and command bundle.
// Used by muldiv_lock_client (optional watchdog: MULDIV_CLIENT_TIMEOUT_EN).
package muldiv_lock_client_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned XLEN = 32;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MFHI  = 4'd4,
    OP_MFLO  = 4'd5,
    OP_MTHI  = 4'd6,
    OP_MTLO  = 4'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } client_state_e;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } mdu_cmd_t;

  function automatic logic is_read(logic [OP_W-1:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/muldiv_lock_client.sv
// Lock-arbitrated client of a shared MDU pool.
// Define MULDIV_CLIENT_TIMEOUT_EN to add a WAIT-state watchdog.
module muldiv_lock_client
  import muldiv_lock_client_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [XLEN-1:0]     cmd_op1,
  input  logic [XLEN-1:0]     cmd_op2,
  input  logic [ID_WIDTH-1:0] cmd_id,
  output logic                lock_req,
  output logic [ID_WIDTH-1:0] lock_id,
  input  logic                lock_grant,
  output logic [OP_W-1:0]     mdu_op,
  output logic [XLEN-1:0]     mdu_op1,
  output logic [XLEN-1:0]     mdu_op2,
  output logic                mdu_start,
  input  logic                mdu_busy,
  input  logic [XLEN-1:0]     mdu_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_data,
  output logic [ID_WIDTH-1:0] rsp_id,
  output logic                rsp_err
);

  client_state_e state;
  mdu_cmd_t      cmd_q;
  logic          blank_q;

`ifdef MULDIV_CLIENT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      blank_q   <= 1'b0;
      cmd_ready <= 1'b1;
      lock_req  <= 1'b0;
      lock_id   <= '0;
      mdu_start <= 1'b0;
      mdu_op    <= '0;
      mdu_op1   <= '0;
      mdu_op2   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef MULDIV_CLIENT_TIMEOUT_EN
      wait_cnt  <= '0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      mdu_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q.op  <= cmd_op;
            cmd_q.op1 <= cmd_op1;
            cmd_q.op2 <= cmd_op2;
            cmd_ready <= 1'b0;
            lock_req  <= 1'b1;
            lock_id   <= cmd_id;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (lock_grant) begin
            mdu_start <= 1'b1;
            mdu_op    <= cmd_q.op;
            mdu_op1   <= cmd_q.op1;
            mdu_op2   <= cmd_q.op2;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!lock_grant) begin
            mdu_op  <= '0;
            mdu_op1 <= '0;
            mdu_op2 <= '0;
            state   <= ST_REQ;
          end else begin
            blank_q  <= 1'b1;
`ifdef MULDIV_CLIENT_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
`ifdef MULDIV_CLIENT_TIMEOUT_EN
          wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          // Losing the lock aborts silently; the op is simply reissued.
          if (!lock_grant) begin
            mdu_op  <= '0;
            mdu_op1 <= '0;
            mdu_op2 <= '0;
            state   <= ST_REQ;
          end
`ifdef MULDIV_CLIENT_TIMEOUT_EN
          else if (timeout) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= lock_id;
            lock_req  <= 1'b0;
            lock_id   <= '0;
            mdu_op    <= '0;
            mdu_op1   <= '0;
            mdu_op2   <= '0;
            state     <= ST_DONE;
          end
`endif
          else if (blank_q) begin
            blank_q <= 1'b0;
          end else if (!mdu_busy) begin
            rsp_valid <= 1'b1;
            rsp_data  <= is_read(cmd_q.op) ? mdu_data : '0;
            rsp_id    <= lock_id;
            lock_req  <= 1'b0;
            lock_id   <= '0;
            mdu_op    <= '0;
            mdu_op1   <= '0;
            mdu_op2   <= '0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
`ifdef MULDIV_CLIENT_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_lock_client.sv
// Randomized self-checking bench for muldiv_lock_client with an MDU pool model.
// Runs the watchdog scenario when MULDIV_CLIENT_TIMEOUT_EN is defined.
module tb_muldiv_lock_client;
  import muldiv_lock_client_pkg::*;

  localparam int IDW = 16;
`ifdef MULDIV_CLIENT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [31:0] cmd_op1, cmd_op2;
  logic [IDW-1:0] cmd_id;
  logic lock_req, lock_grant;
  logic [IDW-1:0] lock_id;
  logic [3:0] mdu_op;
  logic [31:0] mdu_op1, mdu_op2, mdu_data;
  logic mdu_start, mdu_busy;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [IDW-1:0] rsp_id;

  int checks = 0;
  int errors = 0;

  int grant_mode;
  logic grant_man;
  logic grant_rnd = 1'b0;
  int busy_lat;
  logic busy_stuck;
  int busy_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] r_hi, r_lo;
  int starts = 0;
  int rsps = 0;

  always #5 clk = ~clk;

  muldiv_lock_client #(.ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_id(cmd_id),
    .lock_req(lock_req), .lock_id(lock_id), .lock_grant(lock_grant),
    .mdu_op(mdu_op), .mdu_op1(mdu_op1), .mdu_op2(mdu_op2),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .mdu_data(mdu_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  // Architectural HI/LO effect of one MDU op.
  function automatic logic [63:0] exec(logic [3:0] op, logic [31:0] a,
                                       logic [31:0] b, logic [63:0] hl);
    longint sa, sb;
    logic [63:0] r;
    r = hl;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  r = 64'(sa * sb);
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV:   if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b != 0) r = {a % b, a / b};
      OP_MTHI:  r[63:32] = a;
      OP_MTLO:  r[31:0] = a;
      default:  ;
    endcase
    return r;
  endfunction

  assign lock_grant = (grant_mode == 1) ? lock_req :
                      (grant_mode == 2) ? grant_rnd : grant_man;
  assign mdu_busy = busy_stuck || (busy_cnt != 0);
  assign mdu_data = (mdu_op == OP_MFHI) ? m_hi : m_lo;

  always @(posedge clk) begin
    grant_rnd <= ($urandom_range(0, 7) != 0);
    if (mdu_start) starts <= starts + 1;
    if (rsp_valid && rsp_ready) rsps <= rsps + 1;
    if (mdu_start && lock_grant) begin
      {m_hi, m_lo} <= exec(mdu_op, mdu_op1, mdu_op2, {m_hi, m_lo});
      busy_cnt <= busy_lat;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [IDW-1:0] id,
                      output logic [31:0] exp, output bit ok);
    exp = is_read(op) ? ((op == OP_MFHI) ? r_hi : r_lo) : 32'd0;
    {r_hi, r_lo} = exec(op, a, b, {r_hi, r_lo});
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    cmd_op = op;
    cmd_op1 = a;
    cmd_op2 = b;
    cmd_id = id;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n, output bit ok);
    n = 0;
    while (!rsp_valid && n < budget) begin
      cyc();
      n++;
    end
    ok = rsp_valid;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mdu_start) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic pop();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [131:0] v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({lock_req, mdu_start, rsp_valid, rsp_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000",
               {lock_req, mdu_start, rsp_valid, rsp_err});
    end
    v = {lock_id, mdu_op, mdu_op1, mdu_op2, rsp_data, rsp_id};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", v);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    bit ok, ok2;
    int n, s0;
    grant_mode = 1;
    busy_lat = 5;
    s0 = starts;
    send(OP_MULT, 32'd7, 32'd6, 16'h12, exp, ok);
    wait_rsp(60, n, ok2);
    checks++;
    if (!(ok && ok2)) begin
      errors++;
      $display("FAIL mult_rsp got valid=%b want 1", rsp_valid);
    end
    checks++;
    if ({rsp_data, rsp_id, rsp_err} !== {32'd0, 16'h12, 1'b0}) begin
      errors++;
      $display("FAIL mult_fields got %h/%h/%b want 0/0012/0",
               rsp_data, rsp_id, rsp_err);
    end
    pop();
    checks++;
    if (starts - s0 != 1) begin
      errors++;
      $display("FAIL mult_starts got %0d want 1", starts - s0);
    end
    busy_lat = 0;
    send(OP_MFLO, 32'd0, 32'd0, 16'h13, exp, ok);
    wait_rsp(60, n, ok2);
    checks++;
    if (n != 4 || !ok2) begin
      errors++;
      $display("FAIL min_latency got %0d want 4", n);
    end
    checks++;
    if ({rsp_data, rsp_id} !== {32'd42, 16'h13}) begin
      errors++;
      $display("FAIL mflo got %0d/%h want 42/0013", rsp_data, rsp_id);
    end
    pop();
  endtask

  task automatic test_grant_delay();
    logic [31:0] exp;
    bit ok, ok2;
    int n;
    grant_mode = 0;
    grant_man = 1'b0;
    busy_lat = 2;
    send(OP_DIVU, 32'd100, 32'd7, 16'h34, exp, ok);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (lock_req !== 1'b1 || mdu_start !== 1'b0) begin
        errors++;
        $display("FAIL withheld_c%0d got req=%b start=%b want 1/0",
                 i, lock_req, mdu_start);
      end
      cyc();
    end
    grant_man = 1'b1;
    cyc();
    checks++;
    if ({mdu_start, mdu_op, mdu_op1, mdu_op2} !==
        {1'b1, 4'(OP_DIVU), 32'd100, 32'd7}) begin
      errors++;
      $display("FAIL grant_start got %b/%h/%0d/%0d want 1/3/100/7",
               mdu_start, mdu_op, mdu_op1, mdu_op2);
    end
    cyc();
    checks++;
    if (mdu_start !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse got %b want 0", mdu_start);
    end
    wait_rsp(60, n, ok2);
    checks++;
    if (!ok2 || {rsp_data, rsp_id} !== {32'd0, 16'h34}) begin
      errors++;
      $display("FAIL divu_rsp got %b/%h/%h want 1/0/0034",
               rsp_valid, rsp_data, rsp_id);
    end
    pop();
  endtask

  task automatic test_grant_drop();
    logic [31:0] exp;
    bit ok, ok2;
    int n, s0, r0;
    grant_mode = 0;
    grant_man = 1'b1;
    busy_lat = 10;
    s0 = starts;
    r0 = rsps;
    send(OP_MULTU, 32'hFFFF_0001, 32'h3, 16'h56, exp, ok);
    wait_start(ok2);
    repeat (3) cyc();
    grant_man = 1'b0;
    cyc();
    checks++;
    if ({lock_req, mdu_start, rsp_valid, mdu_op} !== {3'b100, 4'd0}) begin
      errors++;
      $display("FAIL drop_to_req got %b/%b/%b/%h want 1/0/0/0",
               lock_req, mdu_start, rsp_valid, mdu_op);
    end
    repeat (3) cyc();
    checks++;
    if (lock_req !== 1'b1 || mdu_start !== 1'b0) begin
      errors++;
      $display("FAIL drop_hold got %b/%b want 1/0", lock_req, mdu_start);
    end
    grant_man = 1'b1;
    busy_lat = 2;
    wait_rsp(60, n, ok2);
    checks++;
    if (!ok2 || starts - s0 != 2) begin
      errors++;
      $display("FAIL reissue got valid=%b starts=%0d want 1/2",
               ok2, starts - s0);
    end
    pop();
    repeat (3) cyc();
    checks++;
    if (rsps - r0 != 1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL one_rsp got %0d/%b want 1/0", rsps - r0, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    bit ok, ok2;
    int n;
    grant_mode = 1;
    busy_lat = 0;
    send(OP_MTHI, 32'hCAFE_BABE, 32'd0, 16'h70, exp, ok);
    wait_rsp(60, n, ok2);
    pop();
    send(OP_MFHI, 32'd0, 32'd0, 16'h78, exp, ok);
    wait_rsp(60, n, ok2);
    checks++;
    if (!ok2 || rsp_data !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL mfhi got %b/%h want 1/cafebabe", ok2, rsp_data);
    end
    cmd_op = OP_MULT;
    cmd_id = 16'hBEEF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({rsp_valid, rsp_data, rsp_id, lock_req, cmd_ready} !==
          {1'b1, 32'hCAFE_BABE, 16'h78, 2'b00}) begin
        errors++;
        $display("FAIL stall_c%0d got %b/%h/%h/%b/%b want 1/cafebabe/0078/0/0",
                 i, rsp_valid, rsp_data, rsp_id, lock_req, cmd_ready);
      end
    end
    cmd_valid = 1'b0;
    pop();
    repeat (2) cyc();
    checks++;
    if ({lock_req, rsp_valid, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL no_queue got %b want 001",
               {lock_req, rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    bit ok, ok2;
    grant_mode = 1;
    busy_lat = 20;
    send(OP_DIV, 32'hFFFF_FFCE, 32'd7, 16'h9A, exp, ok);
    wait_start(ok2);
    repeat (2) cyc();
    checks++;
    if (!ok2 || lock_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got start=%b req=%b want 1/1", ok2, lock_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lock_req, mdu_start, rsp_valid, mdu_op} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got %b/%b/%b/%h want 0",
               lock_req, mdu_start, rsp_valid, mdu_op);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (cmd_ready !== 1'b1 || lock_req !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got ready=%b req=%b want 1/0",
               cmd_ready, lock_req);
    end
  endtask

`ifdef MULDIV_CLIENT_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] exp;
    bit ok, ok2;
    int n;
    grant_mode = 1;
    busy_lat = 0;
    busy_stuck = 1'b1;
    send(OP_MULT, 32'd3, 32'd4, 16'hE1, exp, ok);
    wait_rsp(40, n, ok2);
    checks++;
    if (!ok2 || n != 10) begin
      errors++;
      $display("FAIL timeout_latency got %0d want 10", n);
    end
    checks++;
    if ({rsp_err, rsp_data, rsp_id, lock_req} !==
        {1'b1, 32'd0, 16'hE1, 1'b0}) begin
      errors++;
      $display("FAIL timeout_rsp got %b/%h/%h/%b want 1/0/00e1/0",
               rsp_err, rsp_data, rsp_id, lock_req);
    end
    pop();
    busy_stuck = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp, a, b;
    logic [3:0] op;
    logic [IDW-1:0] id;
    bit ok, done;
    grant_mode = 2;
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (b == 0) b = 32'd1;
      id = IDW'($urandom);
      busy_lat = $urandom_range(0, 6);
      send(op, a, b, id, exp, ok);
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
        if (rsp_valid && $urandom_range(0, 2) == 0) begin
          checks++;
          if ({rsp_data, rsp_id, rsp_err} !== {exp, id, 1'b0}) begin
            errors++;
            $display("FAIL rand_%0d op=%0d got %h/%h/%b want %h/%h/0",
                     k, op, rsp_data, rsp_id, rsp_err, exp, id);
          end
          pop();
          done = 1'b1;
        end else begin
          cyc();
        end
      end
      checks++;
      if (!(ok && done)) begin
        errors++;
        $display("FAIL rand_%0d_stall got accepted=%b done=%b want 1/1",
                 k, ok, done);
      end
    end
    grant_mode = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_op1 = '0;
    cmd_op2 = '0;
    cmd_id = '0;
    rsp_ready = 1'b0;
    grant_mode = 1;
    grant_man = 1'b0;
    busy_lat = 0;
    busy_stuck = 1'b0;
    r_hi = '0;
    r_lo = '0;
    test_reset();
    test_basic();
    test_grant_delay();
    test_grant_drop();
    test_backpressure();
    test_reset_mid();
`ifdef MULDIV_CLIENT_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
